// File: rtl/native_bus_pkg.sv
// Shared types and constants for the native valid/ready bus arbiter.
package native_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } native_bus_t;

endpackage

// File: rtl/native_rr_arb.sv
// Rotating-priority picker: first asserted request at or after the pointer.
module native_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               grant_valid_o
);

  int unsigned idx;

  // Scan from the pointer upward, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_valid_o && req_i[IDX_W'(idx)]) begin
        grant_valid_o = 1'b1;
        grant_o       = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/native_bus_arbiter.sv
// N-master to 1-slave native bus arbiter with static/round-robin selection,
// whole-transaction grant hold, and slave-timeout abort.
module native_bus_arbiter
  import native_bus_pkg::*;
#(
  parameter int unsigned NUM_MSTR    = 4,
  parameter int unsigned SEL_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              mode_i,
  input  logic [SEL_W-1:0]                  sel_i,
  input  logic [NUM_MSTR-1:0]               mstr_valid_i,
  input  logic [NUM_MSTR-1:0][31:0]         mstr_addr_i,
  input  logic [NUM_MSTR-1:0][31:0]         mstr_wdata_i,
  input  logic [NUM_MSTR-1:0][3:0]          mstr_wstrb_i,
  output logic [NUM_MSTR-1:0][31:0]         mstr_rdata_o,
  output logic [NUM_MSTR-1:0]               mstr_ready_o,
  output logic [NUM_MSTR-1:0][31:0]         mstr_irq_o,
  output logic                              core_valid_o,
  output logic [31:0]                       core_addr_o,
  output logic [31:0]                       core_wdata_o,
  output logic [3:0]                        core_wstrb_o,
  input  logic [31:0]                       core_rdata_i,
  input  logic                              core_ready_i,
  input  logic [31:0]                       irq_i,
  output logic [$clog2(NUM_MSTR)-1:0]       grant_o,
  output logic                              busy_o,
  output logic                              timeout_o
);

  localparam int unsigned IDX_W = $clog2(NUM_MSTR);
  localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              sel_in_range;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  rr_grant;
  logic              rr_grant_valid;
  logic              cand_valid;
  logic [IDX_W-1:0]  cand_idx;
  logic [IDX_W-1:0]  grant_inc;
  native_bus_t       core_bus;

  assign sel_in_range = 32'(sel_i) < NUM_MSTR;
  assign sel_idx      = IDX_W'(sel_i);
  assign grant_inc    = (32'(grant_q) == NUM_MSTR - 1) ? '0 : grant_q + IDX_W'(1);

  native_rr_arb #(
    .NUM_REQ (NUM_MSTR)
  ) u_rr_arb (
    .req_i         (mstr_valid_i),
    .ptr_i         (rr_ptr_q),
    .grant_o       (rr_grant),
    .grant_valid_o (rr_grant_valid)
  );

  // Candidate owner for the next arbitration, by current mode.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    if (mode_i == MODE_RR) begin
      cand_valid = rr_grant_valid;
      cand_idx   = rr_grant;
    end else if (sel_in_range && mstr_valid_i[sel_idx]) begin
      cand_valid = 1'b1;
      cand_idx   = sel_idx;
    end
  end

  // Slave-side view of the granted master.
  always_comb begin
    core_bus.valid = mstr_valid_i[grant_q];
    core_bus.addr  = mstr_addr_i[grant_q];
    core_bus.wdata = mstr_wdata_i[grant_q];
    core_bus.wstrb = mstr_wstrb_i[grant_q];
  end

  assign core_addr_o  = core_bus.addr;
  assign core_wdata_o = core_bus.wdata;
  assign core_wstrb_o = core_bus.wstrb;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q == BUSY);

  // IRQ steering: selected master in static mode, master 0 in round-robin.
  always_comb begin
    mstr_irq_o = '0;
    if (mode_i == MODE_RR) begin
      mstr_irq_o[0] = irq_i;
    end else if (sel_in_range) begin
      mstr_irq_o[sel_idx] = irq_i;
    end
  end

  // Next-state and transfer-completion logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    mstr_ready_o = '0;
    mstr_rdata_o = '0;
    timeout_o    = 1'b0;
    core_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cand_valid) begin
          grant_d = cand_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!core_bus.valid) begin
          // Owner withdrew: drop the transfer silently.
          state_d = IDLE;
        end else if (core_ready_i) begin
          core_valid_o          = 1'b1;
          mstr_ready_o[grant_q] = 1'b1;
          mstr_rdata_o[grant_q] = core_rdata_i;
          rr_ptr_d              = grant_inc;
          state_d               = IDLE;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
          mstr_ready_o[grant_q] = 1'b1;
          mstr_rdata_o[grant_q] = ERR_DATA;
          timeout_o             = 1'b1;
          rr_ptr_d              = grant_inc;
          state_d               = IDLE;
        end else begin
          core_valid_o = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset cycle never completes a transfer.
    if (rst_i) begin
      mstr_ready_o = '0;
      mstr_rdata_o = '0;
      timeout_o    = 1'b0;
      core_valid_o = 1'b0;
    end
  end

  // State, owner, pointer and timeout counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_native_bus_arbiter.sv
// Bench for native_bus_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_native_bus_arbiter;

  localparam int NM = 4;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mode;
  logic [4:0]           sel;
  logic [NM-1:0]        mvalid;
  logic [NM-1:0][31:0]  maddr, mwdata, mrdata, mirq;
  logic [NM-1:0][3:0]   mwstrb;
  logic [NM-1:0]        mready;
  logic                 cvalid, cready;
  logic [31:0]          caddr, cwdata, crdata, irq;
  logic [3:0]           cwstrb;
  logic [1:0]           grant;
  logic                 busy, tmo;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner (-1 when idle), BUSY cycles elapsed, rr pointer, last owner.
  int m_owner, m_cnt, m_rr, m_grant;
  int n_owner, n_cnt, n_rr, n_grant;
  logic                e_busy, e_tmo, e_cvalid;
  logic [1:0]          e_grant;
  logic [NM-1:0]       e_ready;
  logic [NM-1:0][31:0] e_rdata, e_irq;

  always #5 clk = ~clk;

  native_bus_arbiter #(
    .NUM_MSTR    (NM),
    .SEL_W       (5),
    .TIMEOUT_CYC (TO),
    .ERR_DATA    (32'hDEAD_BEEF)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mode_i       (mode),
    .sel_i        (sel),
    .mstr_valid_i (mvalid),
    .mstr_addr_i  (maddr),
    .mstr_wdata_i (mwdata),
    .mstr_wstrb_i (mwstrb),
    .mstr_rdata_o (mrdata),
    .mstr_ready_o (mready),
    .mstr_irq_o   (mirq),
    .core_valid_o (cvalid),
    .core_addr_o  (caddr),
    .core_wdata_o (cwdata),
    .core_wstrb_o (cwstrb),
    .core_rdata_i (crdata),
    .core_ready_i (cready),
    .irq_i        (irq),
    .grant_o      (grant),
    .busy_o       (busy),
    .timeout_o    (tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mode = 1'b0; sel = '0; mvalid = '0; cready = 1'b0;
    crdata = '0; irq = '0;
    for (int i = 0; i < NM; i++) begin
      maddr[i]  = 32'h1000 + 32'(i) * 32'h100;
      mwdata[i] = 32'hC0DE_0000 + 32'(i);
      mwstrb[i] = 4'(i + 1);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Expected outputs and next model state from the arbitration rules.
  task automatic predict();
    int g, d, j;
    e_busy = (m_owner >= 0); e_grant = 2'(m_grant);
    e_ready = '0; e_rdata = '0; e_tmo = 1'b0; e_cvalid = 1'b0; e_irq = '0;
    n_owner = m_owner; n_cnt = m_cnt; n_rr = m_rr; n_grant = m_grant;
    d = mode ? 0 : int'(sel);
    if (d < NM) e_irq[2'(d)] = irq;
    if (m_owner < 0) begin
      g = -1;
      if (!mode) begin
        if (int'(sel) < NM && mvalid[2'(sel)]) g = int'(sel);
      end else begin
        for (int k = 0; k < NM; k++) begin
          j = (m_rr + k) % NM;
          if (g < 0 && mvalid[2'(j)]) g = j;
        end
      end
      if (g >= 0) begin n_owner = g; n_grant = g; n_cnt = 0; end
    end else begin
      g = m_owner;
      if (!mvalid[2'(g)]) begin
        n_owner = -1;
      end else if (cready) begin
        e_cvalid = 1'b1; e_ready[2'(g)] = 1'b1; e_rdata[2'(g)] = crdata;
        n_owner = -1; n_rr = (g + 1) % NM;
      end else if (m_cnt == TO - 1) begin
        e_tmo = 1'b1; e_ready[2'(g)] = 1'b1; e_rdata[2'(g)] = 32'hDEAD_BEEF;
        n_owner = -1; n_rr = (g + 1) % NM;
      end else begin
        e_cvalid = 1'b1; n_cnt = m_cnt + 1;
      end
    end
    if (rst) begin
      e_ready = '0; e_rdata = '0; e_tmo = 1'b0; e_cvalid = 1'b0;
      n_owner = -1; n_cnt = 0; n_rr = 0; n_grant = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mvalid = '0; cready = 1'b0; mode = 1'b0; sel = '0; irq = '0; crdata = '0;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({busy, grant, mready, tmo, cvalid} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", {busy, grant, mready, tmo, cvalid}, 9'b0);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_static();
    int pulses = 0;
    bit seen0 = 0;
    do_reset();
    sel = 5'd2; mvalid = 4'b0101; crdata = 32'hA5A5_0002;
    for (int c = 0; c < 6; c++) begin
      cready = (c == 3);
      if (c >= 4) mvalid = '0;
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if ({busy, cvalid} !== 2'b00) begin
          n_fail++; $display("FAIL static_idle: got %b expected 00", {busy, cvalid});
        end
      end else if (c <= 3) begin
        n_checks++;
        if ({busy, grant, cvalid, caddr} !== {1'b1, 2'd2, 1'b1, 32'h0000_1200}) begin
          n_fail++;
          $display("FAIL static_busy c=%0d: got %b/%0d/%b/%h expected 1/2/1/00001200", c, busy, grant, cvalid, caddr);
        end
        n_checks++;
        if (c == 3) begin
          if ({mready, mrdata[2], mrdata[0]} !== {4'b0100, 32'hA5A5_0002, 32'h0}) begin
            n_fail++; $display("FAIL static_done: got %b/%h/%h expected 0100/a5a50002/0", mready, mrdata[2], mrdata[0]);
          end
        end else if (mready !== 4'b0000) begin
          n_fail++; $display("FAIL static_early_ready c=%0d: got %b expected 0000", c, mready);
        end
      end
      if (mready[2]) pulses++;
      if (mready[0]) seen0 = 1;
      tick();
    end
    n_checks++;
    if (pulses != 1 || seen0) begin
      n_fail++; $display("FAIL static_pulses: got %0d pulses m0=%0d expected 1 pulses m0=0", pulses, seen0);
    end
  endtask

  task automatic test_rr();
    int g;
    do_reset();
    mode = 1'b1; mvalid = 4'hF; cready = 1'b1; crdata = 32'h0BAD_F00D;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (c % 2 == 0) begin
        if ({busy, cvalid, mready} !== 6'b0) begin
          n_fail++; $display("FAIL rr_bubble c=%0d: got %b/%b/%b expected 0/0/0000", c, busy, cvalid, mready);
        end
      end else begin
        g = ((c - 1) / 2) % NM;
        if ({busy, grant, mready} !== {1'b1, 2'(g), 4'(1 << g)}) begin
          n_fail++; $display("FAIL rr_order c=%0d: got %b/%0d/%b expected 1/%0d/%b", c, busy, grant, mready, g, 4'(1 << g));
        end
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    sel = 5'd1; mvalid = 4'b0010;
    for (int c = 0; c < 11; c++) begin
      cready = (c == 9);
      if (c == 10) mvalid = '0;
      @(negedge clk);
      if (c >= 1 && c <= 7) begin
        n_checks++;
        if ({busy, tmo, cvalid, mready} !== {3'b101, 4'b0000}) begin
          n_fail++; $display("FAIL to_wait c=%0d: got %b/%b/%b/%b expected 1/0/1/0000", c, busy, tmo, cvalid, mready);
        end
      end else if (c == 8) begin
        n_checks++;
        if ({busy, tmo, cvalid, mready, mrdata[1]} !== {3'b110, 4'b0010, 32'hDEAD_BEEF}) begin
          n_fail++; $display("FAIL to_abort: got %b/%b/%b/%b/%h expected 1/1/0/0010/deadbeef", busy, tmo, cvalid, mready, mrdata[1]);
        end
      end else if (c == 9) begin
        n_checks++;
        if ({busy, tmo, mready, mrdata[1]} !== 38'b0) begin
          n_fail++; $display("FAIL to_late_ready: got %b/%b/%b/%h expected 0/0/0000/0", busy, tmo, mready, mrdata[1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_tie();
    do_reset();
    sel = 5'd1; mvalid = 4'b0010; crdata = 32'h1234_5678;
    for (int c = 0; c < 10; c++) begin
      cready = (c == 8);
      if (c == 9) mvalid = '0;
      @(negedge clk);
      if (c == 8) begin
        n_checks++;
        if ({tmo, cvalid, mready, mrdata[1]} !== {2'b01, 4'b0010, 32'h1234_5678}) begin
          n_fail++; $display("FAIL tie_complete: got %b/%b/%b/%h expected 0/1/0010/12345678", tmo, cvalid, mready, mrdata[1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_sel_switch();
    do_reset();
    sel = 5'd0; mvalid = 4'b0011; irq = 32'h5;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) sel = 5'd1;
      cready = (c == 2);
      if (c == 5) mvalid = '0;
      @(negedge clk);
      n_checks++;
      case (c)
        0: if ({mirq[0], mirq[1]} !== {32'h5, 32'h0}) begin
             n_fail++; $display("FAIL irq_before: got %h/%h expected 5/0", mirq[0], mirq[1]);
           end
        1: if ({busy, grant, mirq[0], mirq[1]} !== {1'b1, 2'd0, 32'h0, 32'h5}) begin
             n_fail++; $display("FAIL sel_mid_busy: got %b/%0d/%h/%h expected 1/0/0/5", busy, grant, mirq[0], mirq[1]);
           end
        2: if ({grant, mready} !== {2'd0, 4'b0001}) begin
             n_fail++; $display("FAIL sel_done_m0: got %0d/%b expected 0/0001", grant, mready);
           end
        3: if (busy !== 1'b0) begin
             n_fail++; $display("FAIL sel_bubble: got %b expected 0", busy);
           end
        4: if ({busy, grant} !== {1'b1, 2'd1}) begin
             n_fail++; $display("FAIL sel_next_m1: got %b/%0d expected 1/1", busy, grant);
           end
        5: if ({mready, cvalid} !== 5'b0) begin
             n_fail++; $display("FAIL drop_valid: got %b/%b expected 0000/0", mready, cvalid);
           end
        default: if (busy !== 1'b0) begin
             n_fail++; $display("FAIL drop_idle: got %b expected 0", busy);
           end
      endcase
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b1; mvalid = 4'b0010; cready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) begin mvalid = 4'b0110; cready = 1'b0; end
      rst = (c == 4);
      if (c == 5) mvalid = 4'hF;
      @(negedge clk);
      if (c == 3) begin
        n_checks++;
        if ({busy, grant} !== {1'b1, 2'd2}) begin
          n_fail++; $display("FAIL rmid_pre: got %b/%0d expected 1/2", busy, grant);
        end
      end else if (c == 5) begin
        n_checks++;
        if ({busy, cvalid, mready, grant} !== 8'b0) begin
          n_fail++; $display("FAIL rmid_after: got %b/%b/%b/%0d expected 0/0/0000/0", busy, cvalid, mready, grant);
        end
      end else if (c == 6) begin
        n_checks++;
        if ({busy, grant} !== {1'b1, 2'd0}) begin
          n_fail++; $display("FAIL rmid_ptr: got %b/%0d expected 1/0", busy, grant);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    m_owner = -1; m_cnt = 0; m_rr = 0; m_grant = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(9) == 0) mvalid[i] = ~mvalid[i];
        maddr[i]  = $urandom;
        mwdata[i] = $urandom;
        mwstrb[i] = 4'($urandom);
      end
      if ($urandom_range(19) == 0) mode = ~mode;
      if ($urandom_range(9) == 0) sel = 5'($urandom_range(5));
      cready = ($urandom_range(5) == 0);
      crdata = $urandom;
      irq    = $urandom;
      rst    = ($urandom_range(99) == 0);
      @(negedge clk);
      predict();
      n_checks++;
      if ({busy, grant, mready, tmo, cvalid} !== {e_busy, e_grant, e_ready, e_tmo, e_cvalid}) begin
        n_fail++;
        $display("FAIL rnd_ctrl c=%0d: got %b expected %b", c, {busy, grant, mready, tmo, cvalid}, {e_busy, e_grant, e_ready, e_tmo, e_cvalid});
      end
      n_checks++;
      if (mrdata !== e_rdata) begin
        n_fail++; $display("FAIL rnd_rdata c=%0d: got %h expected %h", c, mrdata, e_rdata);
      end
      n_checks++;
      if (mirq !== e_irq) begin
        n_fail++; $display("FAIL rnd_irq c=%0d: got %h expected %h", c, mirq, e_irq);
      end
      if (e_busy) begin
        n_checks++;
        if ({caddr, cwdata, cwstrb} !== {maddr[2'(m_grant)], mwdata[2'(m_grant)], mwstrb[2'(m_grant)]}) begin
          n_fail++;
          $display("FAIL rnd_mux c=%0d: got %h/%h/%h expected %h/%h/%h", c, caddr, cwdata, cwstrb,
                   maddr[2'(m_grant)], mwdata[2'(m_grant)], mwstrb[2'(m_grant)]);
        end
      end
      @(posedge clk);
      m_owner = n_owner; m_cnt = n_cnt; m_rr = n_rr; m_grant = n_grant;
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_static();
    test_rr();
    test_timeout();
    test_tie();
    test_sel_switch();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
